lfsr_checker: RTL and testbench

Receive-side companion to the team's LFSR generator. Consumes a stream of WIDTH-bit words, self-synchronises to the generator's LFSR sequence, and then free-runs a local copy of the sequence. Flags word mismatches and keeps saturating error and word counters. Sits at the sink end of any link or datapath driven by the LFSR generator, for BIST and loopback checks.

---
 rtl/lfsr_pkg.sv | 33 +++
 rtl/lfsr_checker.sv | 142 ++++++++++++++
 tb/tb_lfsr_checker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR next-value function, fill constant and checker states
package lfsr_pkg;

  // Value substituted when the register is all zeros, replicated per byte.
  localparam logic [7:0] LFSR_FILL_BYTE = 8'hAA;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lfsr_chk_state_t;

  // Next LFSR value for a 8/16/32-bit register held in the low bits of r.
  // Shift right, feedback enters at the MSB; the all-zero lockup state is
  // escaped by loading the fill pattern. Generator and checker both call this.
  function automatic logic [31:0] lfsr_next(input int width, input logic [31:0] r);
    logic [31:0] mask;
    logic [31:0] cur;
    logic        fb;
    mask = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    cur  = r & mask;
    case (width)
      32:      fb = cur[31] ^ cur[21] ^ cur[1]  ^ cur[0];
      16:      fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
      default: fb = cur[7]  ^ cur[5]  ^ cur[4]  ^ cur[3];
    endcase
    if (cur == 32'd0) begin
      return {4{LFSR_FILL_BYTE}} & mask;
    end
    return ((cur >> 1) | (32'(fb) << (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising LFSR sequence checker with saturating counters
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int LOCK_MATCHES    = 4,
  parameter int LOSS_MISMATCHES = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  input  logic                 clear_counts,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] word_count
);

  generate
    if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : g_bad_width
      $error("lfsr_checker: WIDTH must be 8, 16 or 32");
    end
    if (LOCK_MATCHES < 1 || LOSS_MISMATCHES < 1) begin : g_bad_thresh
      $error("lfsr_checker: LOCK_MATCHES and LOSS_MISMATCHES must be >= 1");
    end
  endgenerate

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int XW = $clog2(LOSS_MISMATCHES + 1);
  // Counter values at which the next hit/miss reaches the threshold.
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_MATCHES - 1);
  localparam logic [XW-1:0] LOSS_LAST = XW'(LOSS_MISMATCHES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] r);
    logic [31:0] t;
    t = lfsr_next(WIDTH, 32'(r));
    return t[WIDTH-1:0];
  endfunction

  lfsr_chk_state_t      state, state_next;
  logic [WIDTH-1:0]     expected, expected_next;
  logic [MW-1:0]        match_cnt, match_cnt_next;
  logic [XW-1:0]        miss_cnt, miss_cnt_next;
  logic                 locked_next;
  logic                 error_next;
  logic [CNT_WIDTH-1:0] err_count_next, word_count_next;

  // State and output registers; reset drops lock and clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEARCH;
      expected   <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
    end else begin
      state      <= state_next;
      expected   <= expected_next;
      match_cnt  <= match_cnt_next;
      miss_cnt   <= miss_cnt_next;
      locked     <= locked_next;
      error      <= error_next;
      err_count  <= err_count_next;
      word_count <= word_count_next;
    end
  end

  // Next-state, local sequence and counter updates for one accepted word.
  always_comb begin
    state_next      = state;
    expected_next   = expected;
    match_cnt_next  = match_cnt;
    miss_cnt_next   = miss_cnt;
    locked_next     = locked;
    error_next      = 1'b0;
    err_count_next  = err_count;
    word_count_next = word_count;

    if (valid_in) begin
      case (state)
        SEARCH: begin
          expected_next  = nxt(data_in);
          match_cnt_next = '0;
          state_next     = ACQUIRE;
        end
        ACQUIRE: begin
          if (data_in == expected) begin
            expected_next  = nxt(expected);
            match_cnt_next = match_cnt + 1'b1;
            if (match_cnt == LOCK_LAST) begin
              state_next    = LOCKED;
              locked_next   = 1'b1;
              miss_cnt_next = '0;
            end
          end else begin
            // Reseed from the received word rather than give up.
            expected_next  = nxt(data_in);
            match_cnt_next = '0;
          end
        end
        LOCKED: begin
          // Free-run: never reseed from data once locked.
          expected_next = nxt(expected);
          if (word_count != CNT_MAX) begin
            word_count_next = word_count + 1'b1;
          end
          if (data_in == expected) begin
            miss_cnt_next = '0;
          end else begin
            error_next    = 1'b1;
            miss_cnt_next = miss_cnt + 1'b1;
            if (err_count != CNT_MAX) begin
              err_count_next = err_count + 1'b1;
            end
            if (miss_cnt == LOSS_LAST) begin
              state_next     = SEARCH;
              locked_next    = 1'b0;
              match_cnt_next = '0;
            end
          end
        end
        default: begin
          state_next  = SEARCH;
          locked_next = 1'b0;
        end
      endcase
    end

    // Clear overrides any same-cycle increment.
    if (clear_counts) begin
      err_count_next  = '0;
      word_count_next = '0;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - randomized model-checked bench for lfsr_checker
module tb_lfsr_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        clear_counts = 1'b0;
  logic        locked, error, locked4, error4;
  logic [15:0] err_count, word_count;
  logic [3:0]  err_count4, word_count4;

  always #5 clk = ~clk;

  lfsr_checker #(.WIDTH(8), .LOCK_MATCHES(LOCK_N), .LOSS_MISMATCHES(LOSS_N), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .clear_counts(clear_counts), .locked(locked), .error(error),
    .err_count(err_count), .word_count(word_count));

  lfsr_checker #(.WIDTH(8), .LOCK_MATCHES(LOCK_N), .LOSS_MISMATCHES(LOSS_N), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .clear_counts(clear_counts), .locked(locked4), .error(error4),
    .err_count(err_count4), .word_count(word_count4));

  // Reference sequence step: taps 7,5,4,3 form mask 0xB8; zero maps to AA.
  function automatic logic [7:0] ref_nxt(input logic [7:0] r);
    logic fb;
    if (r == 8'h00) return 8'hAA;
    fb = ^(r & 8'hB8);
    return {fb, r[7:1]};
  endfunction

  // Behavioural model: mode 0=search 1=acquire 2=locked.
  int         m_mode, m_match, m_miss;
  logic [7:0] m_exp;
  int         m_locked, m_err, m_ec, m_wc, m_ec4, m_wc4;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_exp = 8'h00; m_match = 0; m_miss = 0;
      m_locked = 0; m_err = 0; m_ec = 0; m_wc = 0; m_ec4 = 0; m_wc4 = 0;
    end else begin
      m_err = 0;
      if (valid_in) begin
        if (m_mode == 0) begin
          m_exp = ref_nxt(data_in); m_match = 0; m_mode = 1;
        end else if (m_mode == 1) begin
          if (data_in == m_exp) begin
            m_exp = ref_nxt(m_exp); m_match++;
            if (m_match == LOCK_N) begin m_mode = 2; m_miss = 0; end
          end else begin
            m_exp = ref_nxt(data_in); m_match = 0;
          end
        end else begin
          if (m_wc < 65535) m_wc++;
          if (m_wc4 < 15) m_wc4++;
          if (data_in == m_exp) m_miss = 0;
          else begin
            m_err = 1; m_miss++;
            if (m_ec < 65535) m_ec++;
            if (m_ec4 < 15) m_ec4++;
            if (m_miss == LOSS_N) begin m_mode = 0; m_match = 0; end
          end
          m_exp = ref_nxt(m_exp);
        end
      end
      if (clear_counts) begin m_ec = 0; m_wc = 0; m_ec4 = 0; m_wc4 = 0; end
      m_locked = (m_mode == 2) ? 1 : 0;
    end
  end

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit pin_en = 1'b0;
  string pin_name;
  int p_lk, p_err, p_ec, p_wc, p_wc4;

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: model every cycle, plus hand-computed pins on request.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("locked", int'(locked), m_locked);
      cmp("error", int'(error), m_err);
      cmp("err_count", int'(err_count), m_ec);
      cmp("word_count", int'(word_count), m_wc);
      cmp("locked4", int'(locked4), m_locked);
      cmp("error4", int'(error4), m_err);
      cmp("err_count4", int'(err_count4), m_ec4);
      cmp("word_count4", int'(word_count4), m_wc4);
      if (pin_en) begin
        if (p_lk  >= 0) cmp({pin_name, "_locked"}, int'(locked), p_lk);
        if (p_err >= 0) cmp({pin_name, "_error"}, int'(error), p_err);
        if (p_ec  >= 0) cmp({pin_name, "_err_count"}, int'(err_count), p_ec);
        if (p_wc  >= 0) cmp({pin_name, "_word_count"}, int'(word_count), p_wc);
        if (p_wc4 >= 0) cmp({pin_name, "_word_count4"}, int'(word_count4), p_wc4);
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit clr);
    valid_in = v; data_in = d; clear_counts = clr;
    @(posedge clk); #1;
    valid_in = 1'b0; clear_counts = 1'b0;
  endtask

  task automatic pin(input string name, input int lk, input int er, input int ec, input int wc, input int wc4);
    pin_name = name; p_lk = lk; p_err = er; p_ec = ec; p_wc = wc; p_wc4 = wc4;
    pin_en = 1'b1;
    @(negedge clk); #1;
    pin_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [7:0] seq1 [5] = '{8'hAA, 8'hD5, 8'h6A, 8'h35, 8'h1A};
  logic [7:0] seq2 [5] = '{8'h00, 8'hAA, 8'hD5, 8'h6A, 8'h35};
  logic [7:0] seq5 [8] = '{8'hAA, 8'hD5, 8'h00, 8'h6A, 8'h35, 8'h1A, 8'h0D, 8'h86};

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_reset();
    pin("reset", 0, 0, 0, 0, 0);

    // Lock on the reference sequence.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq1[i], 1'b0);
      if (i == 3) pin("t1_pre", 0, 0, 0, 0, 0);
    end
    pin("t1_lock", 1, 0, 0, 0, 0);

    // Single corrupted word, then the correct next word.
    step(1'b1, 8'h0C, 1'b0);
    pin("t3_err", 1, 1, 1, 1, -1);
    step(1'b1, 8'h86, 1'b0);
    pin("t3_ok", 1, 0, 1, 2, -1);

    // Loss of lock after four misses.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      if (i == 2) pin("t4_hold", 1, 1, 4, 5, -1);
    end
    pin("t4_loss", 0, 1, 5, 6, -1);

    // Zero seed with stalls between words.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq2[i], 1'b0);
      if (i == 3) pin("t2_pre", 0, 0, -1, -1, -1);
      repeat ($urandom_range(1, 3)) step(1'b0, $urandom_range(0, 255), 1'b0);
    end
    pin("t2_lock", 1, 0, 5, 6, -1);

    // Saturation at 4 bits, then clear together with a valid word.
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, m_exp, 1'b0);
    pin("t6_sat", 1, 0, 0, 20, 15);
    step(1'b1, m_exp, 1'b0);
    pin("t6_hold", 1, 0, 0, 21, 15);
    step(1'b1, m_exp, 1'b1);
    pin("t6_clear", 1, 0, 0, 0, 0);

    // Reseed in ACQUIRE restarts the match count.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq5[i], 1'b0);
      if (i == 6) pin("t5_pre", 0, 0, 0, 0, -1);
    end
    pin("t5_lock", 1, 0, 0, 0, -1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit         v;
      logic [7:0] d;
      v = ($urandom_range(0, 9) < 7);
      if (m_mode == 0) d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 15) == 0) d = 8'($urandom_range(0, 255));
      else d = m_exp;
      if ($urandom_range(0, 799) == 0) begin
        reset = 1'b1;
        step(v, d, 1'b0);
        reset = 1'b0;
      end else begin
        step(v, d, ($urandom_range(0, 99) == 0));
      end
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
